alu_status_unit: RTL and testbench
==================================

// Module: alu_status_unit
// PURPOSE
//  8-bit 6502-style execution slice: combinational ALU (binary/BCD add/sub, logic, shifts, rotates),
//  per-bit-enabled processor status register (P), and one bus temp latch. Sits in the CPU datapath
//  between operand buses A/B and the result bus; register outputs are zero-gated for OR-bus merging.
// PARAMETERS
//  WIDTH  8  datapath width; only 8 is supported (BCD and flag positions assume 8).
// PORTS
//  ph2        in   1  clock; all state updates on rising edge
//  reset      in   1  asynchronous, active-high reset
//  a          in   8  ALU operand A
//  b          in   8  ALU operand B
//  alu_op     in   4  operation select (alu_pkg::alu_op_e)
//  c_in       in   1  carry in (add/sub/rotate)
//  bcd        in   1  decimal mode for ADD/SUB
//  y          out  8  ALU result (combinational)
//  flags      out  8  ALU flags: [7]=N [6]=V [1]=Z [0]=C, other bits 0 (combinational)
//  p_in_en    in   8  per-bit P load enables
//  p_sel      in   1  P source: 0=flags, 1=p_data
//  p_data     in   8  bus value for P loads
//  p_out_en   in   1  drive p_bus
//  p_q        out  8  P register contents
//  p_bus      out  8  p_out_en ? p_q : 8'h00
//  t_in_en    in   1  load temp latch from t_data
//  t_data     in   8  temp latch input
//  t_out_en   in   1  drive t_bus
//  t_q        out  8  temp latch contents
//  t_bus      out  8  t_out_en ? t_q : 8'h00
// BEHAVIOUR
//  alu_op: 0 ADD a+b+c_in; 1 SUB a+~b+c_in (c_in=1 means no borrow); 2 AND; 3 OR; 4 EOR;
//   5 ASL a (shift in 0, C=a[7]); 6 LSR a (shift in 0, C=a[0]); 7 ROL a (in c_in, C=a[7]);
//   8 ROR a (in c_in, C=a[0]); 9 PASSA; 10 PASSB; 11 BIT y=a&b, N=b[7], V=b[6];
//   12 INC a+1; 13 DEC a-1; 14-15 reserved = PASSA.
//  N=y[7], Z=(y==0) for all ops except N under BIT. V only for ADD/SUB (signed overflow of the
//   binary result) and BIT; otherwise 0. C is c_in for ops 2-4, 9-15.
//  Decimal (bcd=1, ADD/SUB only): per-nibble adjust; ADD adds 6 when a nibble >9 or carries,
//   C = decimal carry out. SUB subtracts 6 / 0x60 on nibble borrow, C = !borrow.
//   N, Z from adjusted y; V from the binary (pre-adjust) result.
//  All arithmetic mod 256: INC 0xFF->0x00, DEC 0x00->0xFF; wrap sets Z/N normally.
//  P: on clock edge, for each i with p_in_en[i]: p_q[i] <= (p_sel ? p_data[i] : flags[i]);
//   other bits hold. p_in_en=0 holds everything.
//  Temp: t_in_en=1 -> t_q <= t_data; else hold.
//  Reset (async, any time incl. mid-load): p_q=8'h00, t_q=8'h00; p_bus/t_bus follow their
//   enables immediately. y/flags combinational, no reset. Latency: ALU 0 cycles; registers 1 edge.
// CONFIGURATION
//  ALU_BCD_EN defined: decimal mode as above.
//  ALU_BCD_EN undefined: bcd input ignored; ADD/SUB always binary; no BCD logic synthesized.
// STRUCTURE
//  alu_pkg: alu_op_e enum (values above); flag index constants FLAG_C=0, FLAG_Z=1, FLAG_I=2,
//   FLAG_D=3, FLAG_B=4, FLAG_V=6, FLAG_N=7.
//  Sub-module alu_core: purely combinational ALU (a, b, alu_op, c_in, bcd -> y, flags).
//  Top holds P and temp registers plus output gating.
// TESTING
//  ADD 0x50+0x50, c_in=0, bcd=0 -> y=0xA0, N=1, V=1, Z=0, C=0.
//  SUB 0x00-0x01, c_in=1 -> y=0xFF, C=0, N=1; SUB 0x05-0x05, c_in=1 -> y=0x00, Z=1, C=1.
//  BCD ADD 0x15+0x27 -> 0x42, C=0; 0x99+0x01 -> 0x00, C=1, Z=1;
//   BCD SUB 0x10-0x01, c_in=1 -> 0x09, C=1 (without ALU_BCD_EN: 0x0F).
//  ROR a=0x01, c_in=1 -> y=0x80, C=1, N=1; BIT a=0x0F b=0xC0 -> Z=1, N=1, V=1.
//  P: p_q=0x00, ADD 0xFF+0x01, p_in_en=0x03, p_sel=0 -> p_q=0x03;
//   p_sel=1 p_data=0xFF p_in_en=0x80 -> 0x83; assert reset mid-cycle -> 0x00 at once.
//  Temp: load 0xA5, then t_in_en=0 for 3 edges -> t_q=0xA5; t_out_en=0 -> t_bus=0x00.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the ALU/status slice: operation encoding and P-register flag positions.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_EOR   = 4'd4,
    ALU_ASL   = 4'd5,
    ALU_LSR   = 4'd6,
    ALU_ROL   = 4'd7,
    ALU_ROR   = 4'd8,
    ALU_PASSA = 4'd9,
    ALU_PASSB = 4'd10,
    ALU_BIT   = 4'd11,
    ALU_INC   = 4'd12,
    ALU_DEC   = 4'd13,
    ALU_RSV14 = 4'd14,
    ALU_RSV15 = 4'd15
  } alu_op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_I = 2;
  localparam int FLAG_D = 3;
  localparam int FLAG_B = 4;
  localparam int FLAG_V = 6;
  localparam int FLAG_N = 7;

endpackage

// File: rtl/alu_status_unit_if.sv
// Bus bundle between the datapath controller (master) and the ALU/status slice (slave).
interface alu_status_unit_if;

  logic [7:0] a;
  logic [7:0] b;
  logic [3:0] alu_op;
  logic       c_in;
  logic       bcd;
  logic [7:0] y;
  logic [7:0] flags;
  logic [7:0] p_in_en;
  logic       p_sel;
  logic [7:0] p_data;
  logic       p_out_en;
  logic [7:0] p_q;
  logic [7:0] p_bus;
  logic       t_in_en;
  logic [7:0] t_data;
  logic       t_out_en;
  logic [7:0] t_q;
  logic [7:0] t_bus;

  modport slave (
    input  a, b, alu_op, c_in, bcd, p_in_en, p_sel, p_data, p_out_en, t_in_en, t_data, t_out_en,
    output y, flags, p_q, p_bus, t_q, t_bus
  );

  modport master (
    output a, b, alu_op, c_in, bcd, p_in_en, p_sel, p_data, p_out_en, t_in_en, t_data, t_out_en,
    input  y, flags, p_q, p_bus, t_q, t_bus
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational 8-bit ALU with 6502-style flags.
// Decimal ADD/SUB exists only when ALU_BCD_EN is defined; otherwise bcd is ignored.
module alu_core
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] alu_op,
  input  logic       c_in,
  input  logic       bcd,
  output logic [7:0] y,
  output logic [7:0] flags
);

  alu_op_e    op_s;
  logic [7:0] b_eff_s;
  logic [8:0] sum_bin_s;
  logic       v_bin_s;
  logic       use_dec_s;
  logic [7:0] dec_y_s;
  logic       dec_c_s;
  logic [7:0] res_s;
  logic       c_s;
  logic       v_s;
  logic       n_s;

  assign op_s = alu_op_e'(alu_op);

  // SUB is a + ~b + c_in, so one adder serves both; V is signed overflow of that sum.
  always_comb begin
    b_eff_s   = (op_s == ALU_SUB) ? ~b : b;
    sum_bin_s = {1'b0, a} + {1'b0, b_eff_s} + {8'h00, c_in};
    v_bin_s   = (a[7] == b_eff_s[7]) && (sum_bin_s[7] != a[7]);
  end

`ifdef ALU_BCD_EN
  logic [5:0] lo_s;
  logic [5:0] hi_s;
  logic       lo_cy_s;

  // Nibble-serial decimal adjust; six bits per nibble so invalid digits still carry/borrow.
  always_comb begin
    lo_s    = 6'h00;
    hi_s    = 6'h00;
    lo_cy_s = 1'b0;
    dec_c_s = 1'b0;
    if (op_s == ALU_SUB) begin
      lo_s    = {2'b00, a[3:0]} - {2'b00, b[3:0]} - {5'b00000, ~c_in};
      lo_cy_s = lo_s[5];
      if (lo_cy_s) begin
        lo_s = lo_s - 6'd6;
      end else begin
        lo_s = lo_s;
      end
      hi_s    = {2'b00, a[7:4]} - {2'b00, b[7:4]} - {5'b00000, lo_cy_s};
      dec_c_s = ~hi_s[5];
      if (hi_s[5]) begin
        hi_s = hi_s - 6'd6;
      end else begin
        hi_s = hi_s;
      end
    end else begin
      lo_s = {2'b00, a[3:0]} + {2'b00, b[3:0]} + {5'b00000, c_in};
      if (lo_s > 6'd9) begin
        lo_s = lo_s + 6'd6;
      end else begin
        lo_s = lo_s;
      end
      lo_cy_s = (lo_s > 6'd15);
      hi_s    = {2'b00, a[7:4]} + {2'b00, b[7:4]} + {5'b00000, lo_cy_s};
      if (hi_s > 6'd9) begin
        hi_s = hi_s + 6'd6;
      end else begin
        hi_s = hi_s;
      end
      dec_c_s = (hi_s > 6'd15);
    end
    dec_y_s   = {hi_s[3:0], lo_s[3:0]};
    use_dec_s = bcd && ((op_s == ALU_ADD) || (op_s == ALU_SUB));
  end
`else
  logic unused_bcd_s;

  assign unused_bcd_s = bcd;
  assign use_dec_s    = 1'b0;
  assign dec_y_s      = sum_bin_s[7:0];
  assign dec_c_s      = sum_bin_s[8];
`endif

  // Result and C per operation; C passes c_in through for ops that do not define it.
  always_comb begin
    res_s = a;
    c_s   = c_in;
    v_s   = 1'b0;
    case (op_s)
      ALU_ADD, ALU_SUB: begin
        res_s = use_dec_s ? dec_y_s : sum_bin_s[7:0];
        c_s   = use_dec_s ? dec_c_s : sum_bin_s[8];
        v_s   = v_bin_s;
      end
      ALU_AND:   res_s = a & b;
      ALU_OR:    res_s = a | b;
      ALU_EOR:   res_s = a ^ b;
      ALU_ASL: begin
        res_s = {a[6:0], 1'b0};
        c_s   = a[7];
      end
      ALU_LSR: begin
        res_s = {1'b0, a[7:1]};
        c_s   = a[0];
      end
      ALU_ROL: begin
        res_s = {a[6:0], c_in};
        c_s   = a[7];
      end
      ALU_ROR: begin
        res_s = {c_in, a[7:1]};
        c_s   = a[0];
      end
      ALU_PASSA: res_s = a;
      ALU_PASSB: res_s = b;
      ALU_BIT: begin
        res_s = a & b;
        v_s   = b[6];
      end
      ALU_INC:   res_s = a + 8'd1;
      ALU_DEC:   res_s = a - 8'd1;
      default:   res_s = a;
    endcase
  end

  assign n_s   = (op_s == ALU_BIT) ? b[7] : res_s[7];
  assign y     = res_s;
  assign flags = {n_s, v_s, 4'b0000, (res_s == 8'h00), c_s};

endmodule

// File: rtl/alu_status_unit.sv
// 6502-style execution slice: ALU, per-bit-loadable status register P, temp latch, zero-gated bus drivers.
// Optional decimal mode is selected by defining ALU_BCD_EN.
module alu_status_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             ph2,
  input  logic             reset,
  alu_status_unit_if.slave bus
);

  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] p_q;
  logic [WIDTH-1:0] t_d;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] p_src_s;

  alu_core u_core (
    .a      (bus.a),
    .b      (bus.b),
    .alu_op (bus.alu_op),
    .c_in   (bus.c_in),
    .bcd    (bus.bcd),
    .y      (bus.y),
    .flags  (bus.flags)
  );

  // Each P bit loads independently from flags or the bus; unselected bits hold.
  always_comb begin
    p_src_s = bus.p_sel ? bus.p_data : bus.flags;
    p_d     = (bus.p_in_en & p_src_s) | (~bus.p_in_en & p_q);
    if (bus.t_in_en) begin
      t_d = bus.t_data;
    end else begin
      t_d = t_q;
    end
  end

  // State registers.
  always_ff @(posedge ph2 or posedge reset) begin
    if (reset) begin
      p_q <= 8'h00;
      t_q <= 8'h00;
    end else begin
      p_q <= p_d;
      t_q <= t_d;
    end
  end

  assign bus.p_q   = p_q;
  assign bus.t_q   = t_q;
  assign bus.p_bus = bus.p_out_en ? p_q : 8'h00;
  assign bus.t_bus = bus.t_out_en ? t_q : 8'h00;

endmodule

// File: tb/tb_alu_status_unit.sv
// Self-checking bench for alu_status_unit: directed vectors plus an arithmetic reference model.
module tb_alu_status_unit;

  logic ph2 = 1'b0;
  logic reset;
  logic chk_en = 1'b0;
  int total = 0;
  int bad = 0;

`ifdef ALU_BCD_EN
  localparam bit BCD_ON = 1'b1;
`else
  localparam bit BCD_ON = 1'b0;
`endif

  alu_status_unit_if bus ();

  alu_status_unit #(.WIDTH(8)) dut (
    .ph2   (ph2),
    .reset (reset),
    .bus   (bus)
  );

  always #5 ph2 = ~ph2;

  function automatic int to_bcd(input int x);
    return (x / 10) * 16 + (x % 10);
  endfunction

  // Reference ALU from arithmetic rules: returns {y, flags}.
  function automatic logic [15:0] model_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                            input logic c, input logic d);
    int ai, bi, ci, r, sa, sb, sr, da, db, dr;
    logic [7:0] y;
    logic n, v, z, cy;
    bit dec;
    ai = int'(a);
    bi = int'(b);
    ci = c ? 1 : 0;
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    da = (ai / 16) * 10 + (ai % 16);
    db = (bi / 16) * 10 + (bi % 16);
    dec = BCD_ON && d;
    v = 1'b0;
    cy = c;
    r = ai;
    case (op)
      4'd0: begin
        r = ai + bi + ci;
        sr = sa + sb + ci;
        v = (sr > 127) || (sr < -128);
        cy = (r > 255);
        if (dec) begin
          dr = da + db + ci;
          cy = (dr >= 100);
          r = to_bcd(dr % 100);
        end
      end
      4'd1: begin
        r = ai - bi - (1 - ci);
        sr = sa - sb - (1 - ci);
        v = (sr > 127) || (sr < -128);
        cy = (r >= 0);
        if (dec) begin
          dr = da - db - (1 - ci);
          cy = (dr >= 0);
          r = to_bcd((dr + 200) % 100);
        end
      end
      4'd2: r = ai & bi;
      4'd3: r = ai | bi;
      4'd4: r = ai ^ bi;
      4'd5: begin r = (ai * 2) % 256; cy = (ai >= 128); end
      4'd6: begin r = ai / 2; cy = (ai % 2 == 1); end
      4'd7: begin r = (ai * 2 + ci) % 256; cy = (ai >= 128); end
      4'd8: begin r = ai / 2 + ci * 128; cy = (ai % 2 == 1); end
      4'd9: r = ai;
      4'd10: r = bi;
      4'd11: begin r = ai & bi; v = b[6]; end
      4'd12: r = ai + 1;
      4'd13: r = ai - 1;
      default: r = ai;
    endcase
    y = 8'((r + 512) % 256);
    n = (op == 4'd11) ? b[7] : y[7];
    z = (y == 8'h00);
    return {y, n, v, 4'b0000, z, cy};
  endfunction

  logic [15:0] mdl;
  logic [7:0] mp;
  logic [7:0] mt;

  assign mdl = model_alu(bus.alu_op, bus.a, bus.b, bus.c_in, bus.bcd);

  // Register model: P bits and temp latch from the load rules.
  always @(posedge ph2 or posedge reset) begin
    if (reset) begin
      mp <= 8'h00;
      mt <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.p_in_en[i]) mp[i] <= bus.p_sel ? bus.p_data[i] : mdl[i];
      end
      if (bus.t_in_en) mt <= bus.t_data;
    end
  end

  task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%02h want=%02h at %0t", name, got, exp, $time);
    end
  endtask

  // Every cycle: all outputs against the model.
  always @(negedge ph2) begin
    if (chk_en) begin
      check8("model.y", bus.y, mdl[15:8]);
      check8("model.flags", bus.flags, mdl[7:0]);
      check8("model.p_q", bus.p_q, mp);
      check8("model.t_q", bus.t_q, mt);
      check8("model.p_bus", bus.p_bus, bus.p_out_en ? mp : 8'h00);
      check8("model.t_bus", bus.t_bus, bus.t_out_en ? mt : 8'h00);
    end
  end

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic d);
    bus.alu_op = op;
    bus.a = a;
    bus.b = b;
    bus.c_in = c;
    bus.bcd = d;
  endtask

  task automatic vec(input string name, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic d, input logic [7:0] ey, input logic [7:0] ef);
    @(posedge ph2);
    #2;
    drive(op, a, b, c, d);
    #1;
    check8({name, ".y"}, bus.y, ey);
    check8({name, ".flags"}, bus.flags, ef);
  endtask

  logic [7:0] vals [5];

  initial begin
    vals[0] = 8'h00; vals[1] = 8'h09; vals[2] = 8'h45; vals[3] = 8'h50; vals[4] = 8'h99;
    reset = 1'b1;
    drive(4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    bus.p_in_en = 8'hFF; bus.p_sel = 1'b1; bus.p_data = 8'hFF; bus.p_out_en = 1'b1;
    bus.t_in_en = 1'b1; bus.t_data = 8'hFF; bus.t_out_en = 1'b1;
    #3;
    check8("rst.p_q", bus.p_q, 8'h00);
    check8("rst.t_q", bus.t_q, 8'h00);
    @(posedge ph2);
    #1;
    check8("rst_hold.p_bus", bus.p_bus, 8'h00);
    check8("rst_hold.t_bus", bus.t_bus, 8'h00);
    bus.p_in_en = 8'h00; bus.t_in_en = 1'b0; bus.p_sel = 1'b0;
    @(negedge ph2);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;

    vec("add_50_50", 4'd0, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 8'hC0);
    vec("add_80_80", 4'd0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h43);
    vec("sub_00_01", 4'd1, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 8'h80);
    vec("sub_05_05", 4'd1, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00, 8'h03);
    vec("bcd_add_15_27", 4'd0, 8'h15, 8'h27, 1'b0, 1'b1, BCD_ON ? 8'h42 : 8'h3C, 8'h00);
    vec("bcd_add_99_01", 4'd0, 8'h99, 8'h01, 1'b0, 1'b1, BCD_ON ? 8'h00 : 8'h9A, BCD_ON ? 8'h03 : 8'h80);
    vec("bcd_sub_10_01", 4'd1, 8'h10, 8'h01, 1'b1, 1'b1, BCD_ON ? 8'h09 : 8'h0F, 8'h01);
    vec("ror_01", 4'd8, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 8'h81);
    vec("bit_0f_c0", 4'd11, 8'h0F, 8'hC0, 1'b0, 1'b0, 8'h00, 8'hC2);
    vec("inc_ff", 4'd12, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02);
    vec("dec_00", 4'd13, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h81);
    vec("asl_81", 4'd5, 8'h81, 8'h00, 1'b0, 1'b0, 8'h02, 8'h01);
    vec("lsr_01", 4'd6, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h03);
    vec("rol_80", 4'd7, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 8'h03);
    vec("and_f0_0f", 4'd2, 8'hF0, 8'h0F, 1'b1, 1'b0, 8'h00, 8'h03);
    vec("eor_ff_0f", 4'd4, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 8'h80);
    vec("ora_00_00", 4'd3, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h02);
    vec("passb_7f", 4'd10, 8'h12, 8'h7F, 1'b0, 1'b0, 8'h7F, 8'h00);
    vec("rsv15_80", 4'd15, 8'h80, 8'h00, 1'b1, 1'b0, 8'h80, 8'h81);

    // P register: flags path then bus path on separate bits.
    @(posedge ph2);
    #2;
    drive(4'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
    bus.p_in_en = 8'h03; bus.p_sel = 1'b0;
    @(posedge ph2);
    #2;
    bus.p_in_en = 8'h00;
    #1;
    check8("p_flags_load", bus.p_q, 8'h03);
    bus.p_sel = 1'b1; bus.p_data = 8'hFF; bus.p_in_en = 8'h80;
    @(posedge ph2);
    #2;
    bus.p_in_en = 8'h00;
    #1;
    check8("p_data_load", bus.p_q, 8'h83);
    check8("p_bus_on", bus.p_bus, 8'h83);
    bus.p_out_en = 1'b0;
    #1;
    check8("p_bus_off", bus.p_bus, 8'h00);
    bus.p_out_en = 1'b1;

    // Temp latch holds over three idle edges.
    bus.t_data = 8'hA5; bus.t_in_en = 1'b1;
    @(posedge ph2);
    #2;
    bus.t_in_en = 1'b0; bus.t_data = 8'h3C;
    repeat (3) @(posedge ph2);
    #1;
    check8("t_hold", bus.t_q, 8'hA5);
    check8("t_bus_on", bus.t_bus, 8'hA5);
    bus.t_out_en = 1'b0;
    #1;
    check8("t_bus_off", bus.t_bus, 8'h00);
    bus.t_out_en = 1'b1;

    // Asynchronous reset asserted between edges.
    @(posedge ph2);
    #3;
    reset = 1'b1;
    #1;
    check8("midrst.p_q", bus.p_q, 8'h00);
    check8("midrst.t_q", bus.t_q, 8'h00);
    check8("midrst.p_bus", bus.p_bus, 8'h00);
    @(negedge ph2);
    #1;
    reset = 1'b0;

    // Sweep every op over BCD-valid operands with random register traffic.
    for (int op = 0; op < 16; op++) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          for (int k = 0; k < 4; k++) begin
            @(posedge ph2);
            #2;
            drive(4'(op), vals[i], vals[j], k[0], k[1]);
            bus.p_in_en = 8'($urandom);
            bus.p_sel = 1'($urandom);
            bus.p_data = 8'($urandom);
            bus.p_out_en = 1'($urandom);
            bus.t_in_en = 1'($urandom);
            bus.t_data = 8'($urandom);
            bus.t_out_en = 1'($urandom);
          end
        end
      end
    end

    @(negedge ph2);
    #1;
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
